mem_arbiter_rr: RTL and testbench
=================================

// Module: mem_arbiter_rr
// PURPOSE
//  Parametrised N-channel arbiter between the cache/TLB front-ends and the single main-memory port.
//  Generalises the two-channel iCache/dCache arbiter in three ways:
//   - NUM_CH requesters, selectable fixed or round-robin priority;
//   - per-channel write enable;
//   - a WAIT-state watchdog that abandons a hung memory transaction.
//  Sits between the L1 caches (plus any later requesters such as a PTW) and the memory interface.
// PARAMETERS
//  NUM_CH    2    number of requesting channels; ch0 = dCache, ch1 = iCache by convention
//  ADDR_W    20   physical line address width
//  DATA_W    128  cache line width
//  RR_EN     1    0: fixed priority, lowest index wins; 1: round-robin
//  TIMEOUT   0    WAIT-state cycle limit; 0 disables the watchdog
//  CNT_W     16   watchdog counter width; must satisfy TIMEOUT < 2**CNT_W
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous, active-high reset
//  reset_mem_req  in   1               synchronous abort of the current transaction
//  ch_req         in   NUM_CH          per-channel request
//  ch_hit_tlb     in   NUM_CH          per-channel TLB hit; a request is eligible only when hit=1
//  ch_we          in   NUM_CH          per-channel write enable
//  ch_addr        in   NUM_CH*ADDR_W   packed physical addresses; ch i occupies [i*ADDR_W +: ADDR_W]
//  ch_wdata       in   NUM_CH*DATA_W   packed write data
//  ch_ready       out  NUM_CH          one-hot completion pulse to the granted channel
//  ch_rdata       out  DATA_W          data_from_mem broadcast to all channels
//  mem_addr       out  ADDR_W          address to memory
//  mem_wdata      out  DATA_W          write data to memory
//  mem_we         out  1               write strobe to memory
//  is_mem_req     out  1               memory request valid
//  mem_ready      in   1               memory completion
//  data_from_mem  in   DATA_W          read data from memory
//  grant_id       out  $clog2(NUM_CH)  index of the granted channel (registered)
//  busy           out  1               arbiter is not IDLE
//  timeout_err    out  1               one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  State machine: IDLE -> REQUEST -> WAIT -> IDLE; state and grant are registered.
//  Eligibility: elig[i] = ch_req[i] & ch_hit_tlb[i].
//  IDLE
//   - If any elig bit is set: latch grant_id and go to REQUEST; otherwise stay in IDLE.
//   - All memory outputs are 0.
//  Grant selection
//   - RR_EN=0: lowest eligible index.
//   - RR_EN=1: search starts at last_grant+1 mod NUM_CH.
//   - last_grant updates when the grant is latched.
//   - last_grant resets to NUM_CH-1, so ch0 wins first after reset.
//  REQUEST (1 cycle, unconditional move to WAIT)
//   - is_mem_req=1; mem_addr/mem_wdata/mem_we driven from channel grant_id.
//   - Address and data are muxed live (not captured); the requester holds them until ch_ready.
//  WAIT
//   - Same drive as REQUEST.
//   - On mem_ready=1: ch_ready[grant_id]=1 and is_mem_req=0 combinationally that cycle; next state IDLE.
//   - ch_ready is combinational from (state, grant_id, mem_ready): zero-latency relative to mem_ready.
//   - Minimum transaction length is 3 cycles, IDLE->IDLE, with mem_ready asserted in the first WAIT cycle.
//  Writes
//   - mem_wdata = ch_wdata of the grantee only when ch_we=1, else 0.
//   - mem_we = 0 outside REQUEST/WAIT.
//  Watchdog (TIMEOUT>0 only)
//   - Counter clears on REQUEST and increments each WAIT cycle with mem_ready=0.
//   - When count==TIMEOUT-1 and mem_ready=0: timeout_err pulses for 1 cycle, next state IDLE, no ch_ready.
//  Simultaneous events
//   - mem_ready and watchdog expiry in the same cycle: mem_ready wins, no timeout_err.
//   - reset_mem_req in any state: next state IDLE; last_grant is retained.
//   - reset_mem_req during WAIT with mem_ready=1: the ch_ready pulse still occurs that cycle.
//   - Changes in ch_req/ch_hit_tlb outside IDLE are ignored; there is no preemption.
//  Reset
//   - State IDLE, grant_id 0, last_grant NUM_CH-1, counter 0.
//   - All outputs 0 except ch_rdata = data_from_mem.
//  Width rules
//   - The watchdog counter saturates rather than wrapping.
//   - NUM_CH=1 is legal: grant_id is forced 0, and its width is max(1, $clog2(NUM_CH)).
// TESTING
//  1. NUM_CH=2, RR_EN=0; ch0 and ch1 request with hits every cycle
//     -> ch0 is always granted; ch1 starves until ch0 drops its request.
//  2. NUM_CH=4, RR_EN=1; all four request continuously, mem_ready in the 2nd WAIT cycle
//     -> grants 0,1,2,3,0; each transaction is 4 cycles.
//  3. ch1 requests with ch_hit_tlb[1]=0 for 5 cycles, then hit=1
//     -> no is_mem_req until hit=1; REQUEST on the next cycle; mem_addr = ch1 address.
//  4. ch0 write, we=1, addr=20'hABCDE, wdata=128'h1234
//     -> in REQUEST/WAIT: mem_we=1, mem_addr=20'hABCDE, mem_wdata=128'h1234; ch_ready=4'b0001 on mem_ready.
//  5. TIMEOUT=8, memory never responds
//     -> timeout_err high in exactly one cycle, 8 cycles after REQUEST; IDLE next; ch_ready stays 0.
//     Repeat with mem_ready on the expiry cycle -> ch_ready pulses, no timeout_err.
//  6. reset_mem_req asserted in WAIT; separately, reset asserted mid-transaction
//     -> IDLE next cycle, is_mem_req=0; after reset, ch0 wins the first RR grant.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter between the L1 cache/TLB front-ends and the single main-memory port.
// Fixed or round-robin grant, per-channel write enable and an optional WAIT-state watchdog.
module mem_arbiter_rr #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 128,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16,
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reset_mem_req,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_hit_tlb,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic                     is_mem_req,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        data_from_mem,
  output logic [GW-1:0]            grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [1:0]               dbg_state
);

  // Handshake: (ch_req & ch_hit_tlb) is a channel's valid; the requester holds addr/we/wdata
  // until its one-cycle ch_ready. is_mem_req is valid toward memory, completed by mem_ready.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last;
  logic [CNT_W-1:0]  r_cnt;

  logic [NUM_CH-1:0] w_elig;
  logic              w_any;
  logic [GW-1:0]     w_pick;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;
  logic              w_drive;
  logic              w_done;
  logic              w_expire;

  assign w_elig = ch_req & ch_hit_tlb;
  assign w_any  = |w_elig;

  // Loops run from lowest to highest priority so the last match is the winner.
  always_comb begin
    int w_idx;
    w_pick = '0;
    w_idx  = 0;
    if (RR_EN == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (w_elig[i]) w_pick = GW'(i);
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        w_idx = int'(r_last) + k;
        if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
          if ((i == w_idx) && w_elig[i]) w_pick = GW'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
        w_sel_we    = ch_we[i];
      end
    end
  end

  assign w_drive  = (r_state == S_REQUEST) || (r_state == S_WAIT);
  assign w_done   = (r_state == S_WAIT) && mem_ready;
  // mem_ready on the expiry cycle takes precedence over the watchdog.
  assign w_expire = (TIMEOUT > 0) && (r_state == S_WAIT) && !mem_ready &&
                    (r_cnt == CNT_W'(TIMEOUT - 1));

  assign mem_addr    = w_drive ? w_sel_addr : '0;
  assign mem_we      = w_drive && w_sel_we;
  assign mem_wdata   = (w_drive && w_sel_we) ? w_sel_wdata : '0;
  assign is_mem_req  = w_drive && !w_done;
  assign ch_rdata    = data_from_mem;
  assign grant_id    = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = w_expire;
  assign dbg_state   = r_state;

  always_comb begin
    ch_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = w_done && (r_grant == GW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= GW'(NUM_CH - 1);
      r_cnt   <= '0;
    end else if (reset_mem_req) begin
      // Abort keeps last_grant so round-robin fairness survives the abort.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_state <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done || w_expire) begin
            r_state <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 4-channel round-robin instance with watchdog and a 2-channel
// fixed-priority instance, checked through an expected-grant queue and directed steps.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 128;
  localparam int EW = 2 + 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic            reset, reset_mem_req;
  logic [N-1:0]    ch_req, ch_hit, ch_we;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_wdata;
  logic [N-1:0]    ch_ready;
  logic [DW-1:0]   ch_rdata, mem_wdata, data_from_mem;
  logic [AW-1:0]   mem_addr;
  logic            mem_we, is_mem_req, mem_ready, busy, timeout_err;
  logic [1:0]      grant_id, dbg_state;

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_EN(1), .TIMEOUT(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .reset_mem_req(reset_mem_req),
    .ch_req(ch_req), .ch_hit_tlb(ch_hit), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_ready(ch_ready), .ch_rdata(ch_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .is_mem_req(is_mem_req), .mem_ready(mem_ready), .data_from_mem(data_from_mem),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  logic        fp_reset, fp_mem_ready, fp_mem_we, fp_is_req, fp_busy, fp_to;
  logic [1:0]  fp_req, fp_hit, fp_we, fp_ch_ready, fp_dbg;
  logic [15:0] fp_addr, fp_wdata;
  logic [7:0]  fp_rdata, fp_mem_addr, fp_mem_wdata;
  logic [0:0]  fp_grant;

  mem_arbiter_rr #(.NUM_CH(2), .ADDR_W(8), .DATA_W(8), .RR_EN(0), .TIMEOUT(0), .CNT_W(4)) u_fp (
    .clk(clk), .reset(fp_reset), .reset_mem_req(1'b0),
    .ch_req(fp_req), .ch_hit_tlb(fp_hit), .ch_we(fp_we), .ch_addr(fp_addr), .ch_wdata(fp_wdata),
    .ch_ready(fp_ch_ready), .ch_rdata(fp_rdata), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_we(fp_mem_we), .is_mem_req(fp_is_req), .mem_ready(fp_mem_ready), .data_from_mem(8'h5A),
    .grant_id(fp_grant), .busy(fp_busy), .timeout_err(fp_to), .dbg_state(fp_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur = '0;
  int ready_cnt = 0;
  int req_cyc[$];

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_exp(input int ch);
    logic [DW-1:0] wd;
    wd = ch_we[ch] ? ch_wdata[ch*DW +: DW] : '0;
    exp_q.push_back({2'(ch), ch_we[ch], ch_addr[ch*AW +: AW], wd});
  endtask

  // Memory model: mem_ready asserted in the resp_lat-th WAIT cycle when enabled.
  bit resp_en = 1'b0;
  int resp_lat = 1;
  int wcnt = 0;
  always @(negedge clk) begin
    if (dbg_state == 2'd2) wcnt++;
    else wcnt = 0;
    mem_ready = resp_en && (wcnt == resp_lat);
    #1;
    if (dbg_state == 2'd1) begin
      req_cyc.push_back(cyc);
      chk("sb_pending", 160'(exp_q.size() > 0), 160'd1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      chk("req_fields", {grant_id, mem_we, mem_addr, mem_wdata}, cur);
      chk("req_valid", is_mem_req, 1);
    end else if (dbg_state == 2'd2) begin
      chk("wait_fields", {grant_id, mem_we, mem_addr, mem_wdata}, cur);
      if (mem_ready) begin
        ready_cnt++;
        chk("ready_onehot", ch_ready, 160'd1 << cur[EW-1 -: 2]);
        chk("ready_req_low", is_mem_req, 0);
        chk("rdata_bcast", ch_rdata, data_from_mem);
      end else begin
        chk("no_ready", ch_ready, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int target);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #2;
      if (ready_cnt >= target) break;
    end
    chk("done_in_time", 160'(ready_cnt >= target), 160'd1);
    ch_req = '0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #2;
      if (dbg_state == 2'd1) break;
    end
    chk("req_seen", dbg_state, 2'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    reset = 1'b1; reset_mem_req = 1'b0; mem_ready = 1'b0;
    ch_req = '0; ch_hit = '1; ch_we = '0;
    for (int i = 0; i < N; i++) begin
      ch_addr[i*AW +: AW]  = AW'($urandom_range(0, 1048575));
      ch_wdata[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    end
    data_from_mem = {$urandom, $urandom, $urandom, $urandom};
    fp_reset = 1'b1; fp_req = '0; fp_hit = '1; fp_we = '0;
    fp_addr = {8'hB1, 8'hA0}; fp_wdata = 16'h3344; fp_mem_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_is_mem_req", is_mem_req, 0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_mem_out", {mem_we, mem_addr, mem_wdata}, 0);
    chk("rst_rdata", ch_rdata, data_from_mem);

    // Round-robin, all four requesting, mem_ready in 2nd WAIT cycle
    resp_en = 1'b1; resp_lat = 2;
    ch_req = 4'hF;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    reset = 1'b0;
    wait_done(5);
    chk("rr_txn_count", req_cyc.size(), 5);
    for (int k = 1; k < 5; k++) chk("rr_txn_len", req_cyc[k] - req_cyc[k-1], 4);

    // TLB miss holds off the request
    resp_lat = 1;
    ch_req = 4'b0010; ch_hit = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      chk("miss_no_req", {busy, is_mem_req}, 0);
    end
    push_exp(1);
    ch_hit = 4'b0010;
    @(negedge clk); #2;
    chk("hit_req", is_mem_req, 1);
    chk("hit_addr", mem_addr, ch_addr[AW +: AW]);
    wait_done(6);
    ch_hit = 4'hF;

    // Write from ch0
    ch_addr[0 +: AW] = 20'hABCDE; ch_wdata[0 +: DW] = 128'h1234; ch_we = 4'b0001;
    ch_req = 4'b0001; resp_lat = 2;
    push_exp(0);
    wait_done(7);
    ch_we = '0;

    // Watchdog expiry with memory silent
    resp_en = 1'b0;
    ch_req = 4'b0100;
    push_exp(2);
    wait_req();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #2;
      chk("to_pulse", timeout_err, 160'(k == 8));
      chk("to_no_ready", ch_ready, 0);
      if (k == 8) ch_req = '0;
      if (k == 9) chk("to_idle", busy, 0);
    end

    // mem_ready on the expiry cycle wins
    resp_en = 1'b1; resp_lat = 8;
    ch_req = 4'b1000;
    push_exp(3);
    wait_req();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #2;
      chk("late_no_to", timeout_err, 0);
      if (k == 8) begin
        chk("late_ready", ch_ready, 4'b1000);
        ch_req = '0;
      end
    end
    @(negedge clk); #2;
    chk("late_idle", busy, 0);

    // reset_mem_req in WAIT aborts; last_grant retained
    resp_en = 1'b0;
    ch_req = 4'b0010;
    push_exp(1);
    wait_req();
    @(negedge clk); #2;
    reset_mem_req = 1'b1; ch_req = '0;
    @(negedge clk); #2;
    chk("abort_idle", {busy, is_mem_req}, 0);
    reset_mem_req = 1'b0;
    resp_en = 1'b1; resp_lat = 1;
    ch_req = 4'b0110;
    push_exp(2);
    wait_done(9);

    // reset_mem_req together with mem_ready still completes
    ch_req = 4'b1000;
    push_exp(3);
    wait_req();
    @(negedge clk); #2;
    reset_mem_req = 1'b1;
    #1;
    chk("abort_ready", ch_ready, 4'b1000);
    ch_req = '0;
    @(negedge clk); #2;
    chk("abort_ready_idle", busy, 0);
    reset_mem_req = 1'b0;

    // Reset mid-transaction; ch0 first afterwards
    resp_en = 1'b0;
    ch_req = 4'b0010;
    push_exp(1);
    wait_req();
    @(negedge clk); #2;
    reset = 1'b1; ch_req = '0;
    @(negedge clk); #2;
    chk("midrst_idle", {busy, is_mem_req}, 0);
    chk("midrst_grant", grant_id, 0);
    reset = 1'b0;
    resp_en = 1'b1; resp_lat = 1;
    ch_req = 4'hF;
    push_exp(0);
    wait_done(11);
    chk("sb_drained", exp_q.size(), 0);

    // Fixed priority: ch0 starves ch1 until it drops
    fp_reset = 1'b0;
    fp_req = 2'b11;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      if (fp_dbg == 2'd1) chk("fp_grant0", fp_grant, 0);
      if (fp_ch_ready != 2'b00) begin
        n++;
        chk("fp_ready_ch0", fp_ch_ready, 2'b01);
        if (n == 4) begin
          fp_req = 2'b10;
          break;
        end
      end
    end
    chk("fp_rounds", n, 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #2;
      if (fp_ch_ready != 2'b00) break;
    end
    chk("fp_ready_ch1", fp_ch_ready, 2'b10);
    chk("fp_addr_ch1", fp_mem_addr, 8'hB1);
    fp_req = '0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
